// File: rtl/compute_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | compute_arbiter_pkg : shared types and constants for the arbiter    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package compute_arbiter_pkg;

  localparam int NUM_PROCESSING_UNITS = 4;
  localparam int UNIT_ID_W            = $clog2(NUM_PROCESSING_UNITS);
  localparam int ARB_TIMEOUT_CYCLES   = 1024;
  localparam int VECTOR_W             = 32;
  localparam int MATRIX_W             = 128;

  typedef enum logic [1:0] {
    COMP_ADD    = 2'd0,
    COMP_MUL    = 2'd1,
    COMP_DOT    = 2'd2,
    COMP_MATVEC = 2'd3
  } computation_type_t;

  typedef logic [VECTOR_W-1:0] vector_data_t;
  typedef logic [MATRIX_W-1:0] matrix_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/compute_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | compute_arbiter_if : arbiter <-> shared compute unit handshake      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface compute_arbiter_if
  import compute_arbiter_pkg::*;
#(
  parameter int UID_W = UNIT_ID_W
);
  logic [UID_W-1:0]  cu_unit_id;
  logic              cu_request;
  logic              cu_ready;
  logic              cu_done;
  computation_type_t cu_comp_type;
  vector_data_t      cu_vector_a;
  vector_data_t      cu_vector_b;
  matrix_data_t      cu_matrix;
  vector_data_t      cu_result;

  modport master (
    output cu_unit_id, cu_request, cu_comp_type, cu_vector_a, cu_vector_b, cu_matrix,
    input  cu_ready, cu_done, cu_result
  );

  modport slave (
    input  cu_unit_id, cu_request, cu_comp_type, cu_vector_a, cu_vector_b, cu_matrix,
    output cu_ready, cu_done, cu_result
  );
endinterface
`default_nettype wire

// File: rtl/compute_arbiter_rr_select.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_select : combinational round-robin picker, first req at/after ptr |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module rr_select #(
  parameter int NUM_UNITS = 4,
  parameter int UID_W     = 2
) (
  input  logic [NUM_UNITS-1:0] req,
  input  logic [UID_W-1:0]     rr_ptr,
  output logic [NUM_UNITS-1:0] winner,
  output logic [UID_W-1:0]     index,
  output logic                 any
);

  always_comb begin
    int j;
    winner = '0;
    index  = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_UNITS) j = j - NUM_UNITS;
      if (!any && req[j]) begin
        any       = 1'b1;
        winner[j] = 1'b1;
        index     = UID_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/compute_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | compute_arbiter : round-robin sharing of one compute unit, watchdog |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module compute_arbiter
  import compute_arbiter_pkg::*;
#(
  parameter int NUM_UNITS      = NUM_PROCESSING_UNITS,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES,
  parameter int UID_W          = $clog2(NUM_UNITS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic              [NUM_UNITS-1:0]   req,
  input  computation_type_t [NUM_UNITS-1:0]   req_type,
  input  vector_data_t      [NUM_UNITS-1:0]   req_vec_a,
  input  vector_data_t      [NUM_UNITS-1:0]   req_vec_b,
  input  matrix_data_t      [NUM_UNITS-1:0]   req_matrix,
  output logic              [NUM_UNITS-1:0]   grant,
  output logic              [NUM_UNITS-1:0]   resp_valid,
  output logic                                resp_error,
  output vector_data_t                        resp_result,
  compute_arbiter_if.master                   cu,
  output logic                                busy,
  output logic              [7:0]             timeout_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  arb_state_t           r_state;
  logic [UID_W-1:0]     r_rr_ptr;
  logic [WD_W-1:0]      r_wd;
  logic [NUM_UNITS-1:0] w_sel_onehot;
  logic [UID_W-1:0]     w_sel_idx;
  logic                 w_sel_any;
  logic                 w_wd_expired;

  assign w_wd_expired = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  rr_select #(
    .NUM_UNITS (NUM_UNITS),
    .UID_W     (UID_W)
  ) u_rr_select (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .winner (w_sel_onehot),
    .index  (w_sel_idx),
    .any    (w_sel_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_rr_ptr        <= '0;
      r_wd            <= '0;
      grant           <= '0;
      resp_valid      <= '0;
      resp_error      <= 1'b0;
      resp_result     <= '0;
      busy            <= 1'b0;
      timeout_count   <= '0;
      cu.cu_unit_id   <= '0;
      cu.cu_request   <= 1'b0;
      cu.cu_comp_type <= COMP_ADD;
      cu.cu_vector_a  <= '0;
      cu.cu_vector_b  <= '0;
      cu.cu_matrix    <= '0;
    end else begin
      resp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (enable && w_sel_any) begin
            grant           <= w_sel_onehot;
            cu.cu_unit_id   <= w_sel_idx;
            cu.cu_comp_type <= req_type[w_sel_idx];
            cu.cu_vector_a  <= req_vec_a[w_sel_idx];
            cu.cu_vector_b  <= req_vec_b[w_sel_idx];
            cu.cu_matrix    <= req_matrix[w_sel_idx];
            cu.cu_request   <= 1'b1;
            busy            <= 1'b1;
            r_wd            <= '0;
            r_state         <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          r_wd <= r_wd + 1'b1;
          // A done that coincides with watchdog expiry is honoured as a normal completion
          if (r_state == WAIT && cu.cu_done) begin
            resp_result <= cu.cu_result;
            resp_valid  <= grant;
            resp_error  <= 1'b0;
            r_state     <= RESP;
          end else if (w_wd_expired) begin
            cu.cu_request <= 1'b0;
            resp_result   <= '0;
            resp_error    <= 1'b1;
            resp_valid    <= grant;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            r_state       <= RESP;
          end else if (r_state == ISSUE && cu.cu_ready) begin
            cu.cu_request <= 1'b0;
            r_state       <= WAIT;
          end
        end
        RESP: begin
          grant      <= '0;
          resp_error <= 1'b0;
          busy       <= 1'b0;
          r_rr_ptr   <= (cu.cu_unit_id == UID_W'(NUM_UNITS - 1)) ? '0 : cu.cu_unit_id + 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compute_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_compute_arbiter : directed self-checking bench for the arbiter   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_compute_arbiter;
  import compute_arbiter_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic                      enable;
  logic              [3:0]   req;
  computation_type_t [3:0]   req_type;
  vector_data_t      [3:0]   req_vec_a;
  vector_data_t      [3:0]   req_vec_b;
  matrix_data_t      [3:0]   req_matrix;
  logic              [3:0]   grant;
  logic              [3:0]   resp_valid;
  logic                      resp_error;
  vector_data_t              resp_result;
  logic                      busy;
  logic              [7:0]   timeout_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  compute_arbiter_if #(.UID_W(2)) cu ();

  compute_arbiter #(
    .NUM_UNITS      (4),
    .TIMEOUT_CYCLES (16),
    .UID_W          (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .req           (req),
    .req_type      (req_type),
    .req_vec_a     (req_vec_a),
    .req_vec_b     (req_vec_b),
    .req_matrix    (req_matrix),
    .grant         (grant),
    .resp_valid    (resp_valid),
    .resp_error    (resp_error),
    .resp_result   (resp_result),
    .cu            (cu),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge right after the grant edge; leaves at the first IDLE negedge.
  task automatic run_op(input logic [3:0] g, input logic [1:0] id, input vector_data_t res);
    chk("grant", 128'(g), 128'(grant));
    chk("cu_unit_id", 128'(cu.cu_unit_id), 128'(id));
    chk("cu_request_on", 128'(cu.cu_request), 128'(1));
    cu.cu_ready = 1'b1;
    @(negedge clk);
    cu.cu_ready = 1'b0;
    chk("cu_request_drop", 128'(cu.cu_request), 128'(0));
    repeat (3) @(negedge clk);
    cu.cu_done   = 1'b1;
    cu.cu_result = res;
    @(negedge clk);
    cu.cu_done = 1'b0;
    chk("resp_valid", 128'(resp_valid), 128'(g));
    chk("resp_result", 128'(resp_result), 128'(res));
    chk("resp_error", 128'(resp_error), 128'(0));
    req = req & ~g;
    @(negedge clk);
    chk("resp_valid_pulse", 128'(resp_valid), 128'(0));
    chk("busy_idle", 128'(busy), 128'(0));
    chk("grant_clear", 128'(grant), 128'(0));
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    req          = 4'b0000;
    cu.cu_ready  = 1'b0;
    cu.cu_done   = 1'b0;
    cu.cu_result = '0;
    for (int i = 0; i < 4; i++) begin
      req_type[i]   = computation_type_t'(i);
      req_vec_a[i]  = 32'hA000_0000 + i;
      req_vec_b[i]  = 32'hB000_0000 + i;
      req_matrix[i] = {4{32'hC000_0000 + i}};
    end
    repeat (3) @(negedge clk);

    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_cu_request", 128'(cu.cu_request), 128'(0));
    chk("rst_timeout_count", 128'(timeout_count), 128'(0));

    // All four request together: served 0,1,2,3 then unit 0 again
    rst_n  = 1'b1;
    enable = 1'b1;
    req    = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      run_op(4'(1 << k), 2'(k), 32'h1111_0000 + k);
      @(negedge clk);
    end
    chk("no_grant_without_req", 128'(grant), 128'(0));
    req = 4'b0001;
    @(negedge clk);
    run_op(4'b0001, 2'd0, 32'h2222_0000);

    // Single request from unit 2 (pointer now 1)
    req = 4'b0100;
    @(negedge clk);
    chk("latched_vec_a", 128'(cu.cu_vector_a), 128'(32'hA000_0002));
    chk("latched_vec_b", 128'(cu.cu_vector_b), 128'(32'hB000_0002));
    chk("latched_type", 128'(cu.cu_comp_type), 128'(2));
    chk("latched_matrix", 128'(cu.cu_matrix), {4{32'hC000_0002}});
    chk("busy_op", 128'(busy), 128'(1));
    run_op(4'b0100, 2'd2, 32'hDEAD_BEEF);

    // Timeout: pointer 3, units 0 and 1 request -> unit 0 wins and never completes
    req = 4'b0011;
    @(negedge clk);
    chk("to_grant", 128'(grant), 128'(4'b0001));
    cu.cu_ready = 1'b1;
    @(negedge clk);
    cu.cu_ready = 1'b0;
    repeat (14) @(negedge clk);
    chk("to_not_early", 128'(resp_valid), 128'(0));
    @(negedge clk);
    chk("to_resp_valid", 128'(resp_valid), 128'(4'b0001));
    chk("to_resp_error", 128'(resp_error), 128'(1));
    chk("to_resp_result", 128'(resp_result), 128'(0));
    chk("to_count", 128'(timeout_count), 128'(1));
    req = 4'b0010;
    @(negedge clk);
    chk("to_resp_pulse", 128'(resp_valid), 128'(0));
    chk("to_error_clear", 128'(resp_error), 128'(0));
    @(negedge clk);
    run_op(4'b0010, 2'd1, 32'h3333_0001);

    // enable low holds off grants; pointer now 2
    enable = 1'b0;
    req    = 4'b1111;
    repeat (3) @(negedge clk);
    chk("en_low_grant", 128'(grant), 128'(0));
    chk("en_low_busy", 128'(busy), 128'(0));
    enable = 1'b1;
    @(negedge clk);
    chk("en_high_grant", 128'(grant), 128'(4'b0100));

    // Owner drops req and changes its operand; enable drops mid-operation
    req          = 4'b1011;
    req_vec_a[2] = 32'h5555_5555;
    enable       = 1'b0;
    cu.cu_ready  = 1'b1;
    @(negedge clk);
    cu.cu_ready = 1'b0;
    chk("drop_vec_a_kept", 128'(cu.cu_vector_a), 128'(32'hA000_0002));
    repeat (3) @(negedge clk);
    cu.cu_done   = 1'b1;
    cu.cu_result = 32'h4444_0002;
    @(negedge clk);
    cu.cu_done = 1'b0;
    chk("drop_resp_valid", 128'(resp_valid), 128'(4'b0100));
    chk("drop_resp_result", 128'(resp_result), 128'(32'h4444_0002));
    repeat (3) @(negedge clk);
    chk("en_low_after_op", 128'(grant), 128'(0));
    enable = 1'b1;
    @(negedge clk);
    chk("en_resume_grant", 128'(grant), 128'(4'b1000));

    // Reset while waiting for done
    cu.cu_ready = 1'b1;
    @(negedge clk);
    cu.cu_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_grant", 128'(grant), 128'(0));
    chk("mid_rst_resp_valid", 128'(resp_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_cu_request", 128'(cu.cu_request), 128'(0));
    chk("mid_rst_resp_result", 128'(resp_result), 128'(0));
    chk("mid_rst_vec_a", 128'(cu.cu_vector_a), 128'(0));
    chk("mid_rst_timeout_count", 128'(timeout_count), 128'(0));
    rst_n = 1'b1;
    req   = 4'b1001;
    @(negedge clk);
    run_op(4'b0001, 2'd0, 32'h6666_0000);
    @(negedge clk);
    chk("post_rst_next", 128'(grant), 128'(4'b1000));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/compute_arbiter.md
Name: compute_arbiter

Overview:
- Shares the single shared_compute_unit among NUM_PROCESSING_UNITS processing units.
- Accepts per-unit compute requests, selects one by round-robin, and latches that unit's operands.
- Drives the compute unit's request/ready/done handshake and returns the result to the granted unit.
- Adds a watchdog timeout and status counters; sits between the gen_units array and u_compute in top.

Parameters:
- NUM_UNITS, default NUM_PROCESSING_UNITS (4): number of requesters.
- TIMEOUT_CYCLES, default 1024: cycles allowed from grant to cu_done before abort.
- UID_W, default $clog2(NUM_UNITS) (2): unit-id width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  permits new grants
- req  in  NUM_UNITS  per-unit request, held high until its resp_valid
- req_type  in  NUM_UNITS x computation_type_t  per-unit operation
- req_vec_a  in  NUM_UNITS x vector_data_t  per-unit operand A
- req_vec_b  in  NUM_UNITS x vector_data_t  per-unit operand B
- req_matrix  in  NUM_UNITS x matrix_data_t  per-unit matrix
- grant  out  NUM_UNITS  one-hot, current owner
- resp_valid  out  NUM_UNITS  one-cycle pulse to owner
- resp_error  out  1  qualifies resp_valid; 1 = timeout
- resp_result  out  vector_data_t  result, valid with resp_valid
- cu_unit_id  out  UID_W  owner id to compute unit
- cu_request  out  1  request to compute unit
- cu_ready  in  1  compute unit accepts
- cu_done  in  1  compute unit finished
- cu_comp_type  out  computation_type_t  latched operation
- cu_vector_a  out  vector_data_t  latched operand A
- cu_vector_b  out  vector_data_t  latched operand B
- cu_matrix  out  matrix_data_t  latched matrix
- cu_result  in  vector_data_t  compute unit result
- busy  out  1  state != IDLE
- timeout_count  out  8  saturating timeout tally

Behaviour:
- Reset (synchronous, active-low):
  - State = IDLE, rr_ptr = 0, watchdog = 0, timeout_count = 0.
  - All outputs 0: grant, resp_valid, resp_error, resp_result, cu_* outputs, busy.
- Reset mid-operation: same result. The in-flight op is dropped with no resp_valid; the compute unit sees cu_request fall.
- States: IDLE, ISSUE, WAIT, RESP. All transitions and outputs are registered.
- IDLE:
  - If enable && |req: pick the first requesting unit at or after rr_ptr (wrap modulo NUM_UNITS).
  - Latch that unit's type and operands into the cu_* registers; set grant one-hot and cu_unit_id; go to ISSUE.
  - The winner is visible one cycle after req is sampled.
- ISSUE:
  - cu_request = 1.
  - On cu_ready = 1, the handshake completes in that cycle: cu_request drops next cycle; go to WAIT.
  - cu_done in ISSUE is ignored.
- WAIT:
  - On cu_done: resp_result <= cu_result; resp_valid[owner] <= 1; resp_error <= 0; go to RESP.
- Watchdog:
  - Clears on grant; increments in ISSUE and WAIT.
  - At TIMEOUT_CYCLES-1 without completion: cu_request <= 0, resp_result <= 0, resp_error <= 1, resp_valid[owner] <= 1, timeout_count increments (saturates at 255); go to RESP.
  - If cu_done arrives in the same cycle as the timeout, the done wins and no error is flagged.
- RESP (one cycle):
  - resp_valid drops at exit.
  - grant <= 0; rr_ptr <= owner+1 (wrap at NUM_UNITS); go to IDLE.
  - The owner must drop req in the cycle it sees resp_valid. req from the old owner in the first IDLE cycle is a new request.
- Latency, best case: req at t → grant/cu_request at t+1 → cu_ready at t+1 → WAIT at t+2. cu_done at d → resp_valid at d+1 → IDLE at d+2 → next grant at d+3.
- Owner drops req mid-operation: the op completes on latched operands and resp_valid still pulses.
- Operands changing after grant have no effect.
- enable low mid-operation: the current op finishes; no new grant until enable is high.
- busy = (state != IDLE); grant and cu_unit_id are stable from grant through RESP.

Decomposition:
- accel_pkg gains:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - ARB_TIMEOUT_CYCLES constant
  - UNIT_ID_W = $clog2(NUM_PROCESSING_UNITS)
- Sub-module rr_select: combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr. Outputs: one-hot winner, index, any.
  - Parameterized by NUM_UNITS; verified standalone.

Test Plan:
- Single request: req=0100, cu_ready same cycle, cu_done 5 cycles later with result X → grant=0100 at t+1, cu_unit_id=2, resp_valid=0100 for one cycle with resp_result=X, resp_error=0, busy low at d+2.
- All four request at once, rr_ptr=0, each held until served → grant order 0001, 0010, 0100, 1000, then 0001 again if unit 0 re-requests.
- Timeout with TIMEOUT_CYCLES=16, cu_done never asserted → resp_valid pulses with resp_error=1, resp_result=0, timeout_count=1; next requester is granted normally.
- enable=0 while req=1111 → grant stays 0; enable=1 → unit at rr_ptr granted next cycle.
- rst_n low during WAIT → next cycle all outputs 0, no resp_valid; after release, req=0001 → granted from rr_ptr=0.
- Owner drops req and changes req_vec_a after grant → cu_vector_a keeps the latched value; resp_valid still pulses to the original owner.
